mbus_power_req_sequencer: RTL and testbench

Sequences local sleep and wakeup requests into the single SLEEP_REQ / WAKEUP_REQ / CLR_EXT_INT handshake of the MBus member controller. It sits in the always-on domain beside the member controller and serves NUM_REQ local requesters (layer controller, timers, GPIO wake sources).
- Wakeups are arbitrated round-robin.
- Sleep is issued only when all requesters vote for it.
- Every handshake is bounded by a timeout.

---
 rtl/mbus_power_req_sequencer.sv | 140 ++++++++++++++
 tb/tb_mbus_power_req_sequencer.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mbus_power_req_sequencer.sv
// Turns local wake requests (round-robin) and unanimous sleep votes into the MBus member-controller handshake.
// Outputs registered, 1 cycle from request to WAKEUP_REQ/SLEEP_REQ; every wait state is bounded by TIMEOUT.
module mbus_power_req_sequencer #(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 200,
    parameter int TO_W    = 8,
    localparam int ID_W   = $clog2(NUM_REQ)
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               ENABLE,
    input  logic [NUM_REQ-1:0] WAKE_REQ_IN,
    input  logic [NUM_REQ-1:0] SLEEP_VOTE,
    input  logic               MBUS_BUSY,
    input  logic               MBC_SLEEP,
    input  logic               EXTERNAL_INT,
    output logic               WAKEUP_REQ,
    output logic               SLEEP_REQ,
    output logic               CLR_EXT_INT,
    output logic [NUM_REQ-1:0] WAKE_ACK,
    output logic [ID_W-1:0]    GRANT_ID,
    output logic               TIMEOUT_ERR
);

    typedef enum logic [2:0] {IDLE, WAKE_ASSERT, WAKE_CLR, SLEEP_ASSERT, ASLEEP} state_t;

    state_t             state, state_nxt;
    logic [ID_W-1:0]    ptr, ptr_nxt, grant_nxt, pick;
    logic [TO_W-1:0]    cnt;
    logic [NUM_REQ-1:0] ack_nxt;
    logic               err_nxt, found, wake_go, timed_out;
    logic               ms_meta, ms, es_meta, es;

    function automatic logic [ID_W-1:0] rr_idx(input logic [ID_W-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NUM_REQ) s = s - NUM_REQ;
        return ID_W'(s);
    endfunction

    function automatic logic [ID_W-1:0] next_id(input logic [ID_W-1:0] g);
        return (int'(g) == NUM_REQ - 1) ? '0 : g + ID_W'(1);
    endfunction

    // First requesting index at or after ptr, wrapping around.
    always_comb begin
        pick  = ptr;
        found = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && WAKE_REQ_IN[rr_idx(ptr, i)]) begin
                found = 1'b1;
                pick  = rr_idx(ptr, i);
            end
        end
    end

    assign wake_go   = ENABLE && (|WAKE_REQ_IN);
    assign timed_out = (cnt == TO_W'(TIMEOUT - 1));

    always_comb begin
        state_nxt = state;
        grant_nxt = GRANT_ID;
        ptr_nxt   = ptr;
        ack_nxt   = '0;
        err_nxt   = 1'b0;
        case (state)
            IDLE, ASLEEP: begin
                if (wake_go) begin
                    state_nxt = WAKE_ASSERT;
                    grant_nxt = pick;
                end else if (state == ASLEEP) begin
                    if (!ms) state_nxt = IDLE;
                end else if (ENABLE && (&SLEEP_VOTE) && !MBUS_BUSY && !ms) begin
                    state_nxt = SLEEP_ASSERT;
                end
            end
            WAKE_ASSERT, WAKE_CLR: begin
                if (state == WAKE_ASSERT && es) begin
                    state_nxt = WAKE_CLR;
                end else if (state == WAKE_CLR && !es) begin
                    state_nxt = ms ? ASLEEP : IDLE;
                    ack_nxt   = NUM_REQ'(1) << GRANT_ID;
                    ptr_nxt   = next_id(GRANT_ID);
                end else if (timed_out) begin
                    // Skip past the stuck requester so it cannot starve the others.
                    state_nxt = IDLE;
                    err_nxt   = 1'b1;
                    ptr_nxt   = next_id(GRANT_ID);
                end
            end
            SLEEP_ASSERT: begin
                if (ms) begin
                    state_nxt = ASLEEP;
                end else if ((|WAKE_REQ_IN) || MBUS_BUSY) begin
                    state_nxt = IDLE;
                end else if (timed_out) begin
                    state_nxt = IDLE;
                    err_nxt   = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state       <= IDLE;
            ptr         <= '0;
            cnt         <= '0;
            ms_meta     <= 1'b0;
            ms          <= 1'b0;
            es_meta     <= 1'b0;
            es          <= 1'b0;
            WAKEUP_REQ  <= 1'b0;
            SLEEP_REQ   <= 1'b0;
            CLR_EXT_INT <= 1'b0;
            WAKE_ACK    <= '0;
            GRANT_ID    <= '0;
            TIMEOUT_ERR <= 1'b0;
        end else begin
            ms_meta     <= MBC_SLEEP;
            ms          <= ms_meta;
            es_meta     <= EXTERNAL_INT;
            es          <= es_meta;
            state       <= state_nxt;
            ptr         <= ptr_nxt;
            if (state_nxt != state || state == IDLE || state == ASLEEP)
                cnt <= '0;
            else
                cnt <= cnt + TO_W'(1);
            WAKEUP_REQ  <= (state_nxt == WAKE_ASSERT);
            SLEEP_REQ   <= (state_nxt == SLEEP_ASSERT);
            CLR_EXT_INT <= (state_nxt == WAKE_CLR);
            WAKE_ACK    <= ack_nxt;
            GRANT_ID    <= grant_nxt;
            TIMEOUT_ERR <= err_nxt;
        end
    end

endmodule

// File: tb/tb_mbus_power_req_sequencer.sv
// Randomized and directed bench for mbus_power_req_sequencer with a transaction-level reference model.
module tb_mbus_power_req_sequencer;
    localparam int N  = 4;
    localparam int TO = 10;
    localparam int IW = 2;
    localparam int K_NONE = 0, K_INT = 1, K_CLR = 2, K_SLP = 3;

    logic          CLK = 1'b0;
    logic          RESET, ENABLE, MBUS_BUSY, MBC_SLEEP, EXTERNAL_INT;
    logic [N-1:0]  WAKE_REQ_IN, SLEEP_VOTE;
    logic          WAKEUP_REQ, SLEEP_REQ, CLR_EXT_INT, TIMEOUT_ERR;
    logic [N-1:0]  WAKE_ACK;
    logic [IW-1:0] GRANT_ID;

    mbus_power_req_sequencer #(.NUM_REQ(N), .TIMEOUT(TO), .TO_W(8)) dut (
        .CLK(CLK), .RESET(RESET), .ENABLE(ENABLE), .WAKE_REQ_IN(WAKE_REQ_IN),
        .SLEEP_VOTE(SLEEP_VOTE), .MBUS_BUSY(MBUS_BUSY), .MBC_SLEEP(MBC_SLEEP),
        .EXTERNAL_INT(EXTERNAL_INT), .WAKEUP_REQ(WAKEUP_REQ), .SLEEP_REQ(SLEEP_REQ),
        .CLR_EXT_INT(CLR_EXT_INT), .WAKE_ACK(WAKE_ACK), .GRANT_ID(GRANT_ID),
        .TIMEOUT_ERR(TIMEOUT_ERR)
    );

    always #5 CLK = ~CLK;

    int n_tests = 0, n_fail = 0;
    // Reference model: which handshake is outstanding, whether the controller is asleep.
    int m_kind, m_age, m_ptr, m_grant;
    bit m_asleep, m_err, m_es, m_ms, m_wake;
    logic [N-1:0] m_ack;
    logic [1:0] ext_q, slp_q;
    // Member-controller environment.
    bit rand_mode;
    int int_dly, clr_dly, slp_dly, wq_cnt, cl_cnt, sl_cnt;
    int err_cnt, wq_rises;
    bit prev_wq;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic int rr_pick(input logic [N-1:0] req, input int from);
        logic [2*N-1:0] dbl;
        dbl = {req, req} >> from;
        for (int j = 0; j < N; j++)
            if (dbl[j]) return (from + j) % N;
        return from;
    endfunction

    task automatic model_reset();
        m_kind = K_NONE; m_age = 0; m_ptr = 0; m_grant = 0;
        m_asleep = 0; m_err = 0; m_ack = '0; ext_q = '0; slp_q = '0;
    endtask

    // One clock edge of the reference, using the inputs that edge sampled.
    task automatic model_step();
        if (RESET) begin
            model_reset();
            return;
        end
        m_es = ext_q[1];
        m_ms = slp_q[1];
        ext_q = {ext_q[0], EXTERNAL_INT};
        slp_q = {slp_q[0], MBC_SLEEP};
        m_ack = '0;
        m_err = 0;
        m_wake = ENABLE && (WAKE_REQ_IN != '0);
        case (m_kind)
            K_NONE: begin
                if (m_wake) begin
                    m_grant = rr_pick(WAKE_REQ_IN, m_ptr);
                    m_kind = K_INT; m_age = 0; m_asleep = 0;
                end else if (m_asleep) begin
                    if (!m_ms) m_asleep = 0;
                end else if (ENABLE && SLEEP_VOTE == '1 && !MBUS_BUSY && !m_ms) begin
                    m_kind = K_SLP; m_age = 0;
                end
            end
            K_INT, K_CLR: begin
                if (m_kind == K_INT && m_es) begin
                    m_kind = K_CLR; m_age = 0;
                end else if (m_kind == K_CLR && !m_es) begin
                    m_kind = K_NONE; m_ack[m_grant] = 1'b1;
                    m_ptr = (m_grant + 1) % N; m_asleep = m_ms;
                end else if (m_age == TO - 1) begin
                    m_kind = K_NONE; m_err = 1; m_ptr = (m_grant + 1) % N;
                end else m_age++;
            end
            default: begin
                if (m_ms) begin
                    m_kind = K_NONE; m_asleep = 1;
                end else if (WAKE_REQ_IN != '0 || MBUS_BUSY) begin
                    m_kind = K_NONE;
                end else if (m_age == TO - 1) begin
                    m_kind = K_NONE; m_err = 1;
                end else m_age++;
            end
        endcase
    endtask

    task automatic env_step();
        if (RESET) return;
        if (WAKEUP_REQ) begin
            wq_cnt++;
            if (wq_cnt >= int_dly) EXTERNAL_INT = 1'b1;
        end else wq_cnt = 0;
        if (CLR_EXT_INT) begin
            cl_cnt++;
            if (cl_cnt >= clr_dly) EXTERNAL_INT = 1'b0;
        end else cl_cnt = 0;
        if (SLEEP_REQ) begin
            sl_cnt++;
            if (sl_cnt >= slp_dly) MBC_SLEEP = 1'b1;
        end else sl_cnt = 0;
        if (rand_mode && MBC_SLEEP && !SLEEP_REQ && $urandom_range(0, 39) == 0) MBC_SLEEP = 1'b0;
    endtask

    task automatic cyc();
        logic [9:0] got_v, exp_v;
        @(negedge CLK);
        model_step();
        got_v = {WAKEUP_REQ, SLEEP_REQ, CLR_EXT_INT, WAKE_ACK, GRANT_ID, TIMEOUT_ERR};
        exp_v = {m_kind == K_INT, m_kind == K_SLP, m_kind == K_CLR, m_ack, IW'(m_grant), m_err};
        check("outputs_vs_model", got_v, exp_v);
        check("req_exclusive", ($countones({WAKEUP_REQ, SLEEP_REQ, CLR_EXT_INT}) <= 1), 1);
        if (TIMEOUT_ERR) err_cnt++;
        if (WAKEUP_REQ && !prev_wq) wq_rises++;
        prev_wq = WAKEUP_REQ;
        env_step();
    endtask

    task automatic reset_dut();
        @(negedge CLK);
        #2 RESET = 1'b1;
        model_reset();
        EXTERNAL_INT = 1'b0; MBC_SLEEP = 1'b0;
        wq_cnt = 0; cl_cnt = 0; sl_cnt = 0;
        cyc(); cyc();
        RESET = 1'b0;
        wq_rises = 0;
    endtask

    task automatic wait_ack(input bit drop, output logic [N-1:0] a);
        a = '0;
        for (int k = 0; k < 60; k++) begin
            cyc();
            if (drop && WAKEUP_REQ) WAKE_REQ_IN = '0;
            if (WAKE_ACK != '0) begin
                a = WAKE_ACK;
                break;
            end
        end
    endtask

    initial begin
        logic [N-1:0] a;
        bit seen_wq, seen_clr, clr_at_ack, flag;
        int n, e0;
        logic [IW-1:0] gid;

        RESET = 1'b1; ENABLE = 1'b0; WAKE_REQ_IN = '0; SLEEP_VOTE = '0;
        MBUS_BUSY = 1'b0; MBC_SLEEP = 1'b0; EXTERNAL_INT = 1'b0;
        rand_mode = 0; int_dly = 5; clr_dly = 4; slp_dly = 3;
        wq_cnt = 0; cl_cnt = 0; sl_cnt = 0; err_cnt = 0; wq_rises = 0; prev_wq = 0;
        model_reset();
        repeat (3) cyc();
        check("reset_outputs", {WAKEUP_REQ, SLEEP_REQ, CLR_EXT_INT, WAKE_ACK, GRANT_ID, TIMEOUT_ERR}, 10'd0);
        RESET = 1'b0; ENABLE = 1'b1;
        cyc();

        // Single wake from requester 2, request dropped mid-handshake.
        WAKE_REQ_IN = 4'b0100;
        seen_wq = 0; seen_clr = 0; clr_at_ack = 0; a = '0; gid = '0;
        for (int k = 0; k < 60; k++) begin
            cyc();
            if (k == 0) check("wake_req_latency", WAKEUP_REQ, 1);
            if (WAKEUP_REQ) begin seen_wq = 1; WAKE_REQ_IN = '0; end
            if (CLR_EXT_INT && seen_wq) seen_clr = 1;
            if (WAKE_ACK != '0) begin
                a = WAKE_ACK; gid = GRANT_ID; clr_at_ack = CLR_EXT_INT;
                break;
            end
        end
        check("single_ack", a, 4'b0100);
        check("single_grant", gid, 2);
        check("single_order", {seen_wq, seen_clr, clr_at_ack}, 3'b110);

        // Round robin with all requests held.
        reset_dut();
        WAKE_REQ_IN = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            wait_ack(0, a);
            check("rr_ack", a, 4'b0001 << (i % 4));
        end
        check("rr_one_ack_per_handshake", wq_rises, 5);
        WAKE_REQ_IN = '0;
        repeat (40) cyc();

        // Sleep gating.
        SLEEP_VOTE = 4'b0111; flag = 0;
        repeat (6) begin cyc(); flag |= SLEEP_REQ; end
        check("sleep_partial_vote", flag, 0);
        SLEEP_VOTE = 4'b1111; MBUS_BUSY = 1'b1; flag = 0;
        repeat (6) begin cyc(); flag |= SLEEP_REQ; end
        check("sleep_bus_busy", flag, 0);
        MBUS_BUSY = 1'b0; e0 = err_cnt;
        cyc();
        check("sleep_req_latency", SLEEP_REQ, 1);
        for (int k = 0; k < 20 && SLEEP_REQ; k++) cyc();
        check("sleep_entered", {SLEEP_REQ, MBC_SLEEP}, 2'b01);
        check("sleep_no_timeout", err_cnt - e0, 0);
        flag = 0;
        repeat (6) begin cyc(); flag |= SLEEP_REQ; end
        check("asleep_no_rerequest", flag, 0);

        // Wake from ASLEEP returns to ASLEEP.
        WAKE_REQ_IN = 4'b0010;
        wait_ack(1, a);
        check("asleep_wake_ack", a, 4'b0010);
        flag = 0;
        repeat (6) begin cyc(); flag |= SLEEP_REQ | WAKEUP_REQ; end
        check("asleep_after_wake", flag, 0);

        // Wake arriving during SLEEP_ASSERT aborts the sleep request.
        slp_dly = 100; MBC_SLEEP = 1'b0; e0 = err_cnt;
        for (int k = 0; k < 15 && !SLEEP_REQ; k++) cyc();
        check("sleep_reasserted", SLEEP_REQ, 1);
        WAKE_REQ_IN = 4'b0010;
        cyc();
        check("sleep_abort", {SLEEP_REQ, WAKEUP_REQ}, 2'b00);
        cyc();
        check("wake_after_abort", {WAKEUP_REQ, GRANT_ID}, 3'b101);
        wait_ack(1, a);
        check("abort_wake_ack", a, 4'b0010);
        check("abort_no_timeout", err_cnt - e0, 0);
        slp_dly = 3;

        // Stuck EXTERNAL_INT times out and advances the pointer.
        reset_dut();
        SLEEP_VOTE = '0; int_dly = 1000;
        WAKE_REQ_IN = 4'b0011;
        cyc();
        n = 0; flag = 0;
        while (WAKEUP_REQ && n < 40) begin
            n++;
            if (WAKE_ACK != '0) flag = 1;
            cyc();
        end
        check("timeout_req_len", n, TO);
        check("timeout_err_pulse", {TIMEOUT_ERR, WAKE_ACK}, 5'b10000);
        cyc();
        check("timeout_err_width", TIMEOUT_ERR, 0);
        check("timeout_no_ack", flag, 0);
        check("timeout_next_grant", {WAKEUP_REQ, GRANT_ID}, 3'b101);
        WAKE_REQ_IN = '0; int_dly = 2;
        repeat (30) cyc();

        // Asynchronous reset in the middle of CLR_EXT_INT.
        clr_dly = 8; WAKE_REQ_IN = 4'b1111;
        for (int k = 0; k < 30 && !CLR_EXT_INT; k++) cyc();
        check("clr_reached", CLR_EXT_INT, 1);
        #2 RESET = 1'b1;
        model_reset();
        #1 check("async_reset_outputs", {WAKEUP_REQ, SLEEP_REQ, CLR_EXT_INT, WAKE_ACK, GRANT_ID, TIMEOUT_ERR}, 10'd0);
        EXTERNAL_INT = 1'b0; MBC_SLEEP = 1'b0; wq_cnt = 0; cl_cnt = 0; sl_cnt = 0;
        cyc(); cyc();
        RESET = 1'b0;
        cyc();
        check("restart_grant0", {WAKEUP_REQ, GRANT_ID}, 3'b100);
        WAKE_REQ_IN = '0; clr_dly = 3;
        repeat (30) cyc();

        // Randomized traffic against the model.
        rand_mode = 1;
        for (int c = 0; c < 4000; c++) begin
            cyc();
            if ($urandom_range(0, 9) == 0)
                WAKE_REQ_IN = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000;
            if ($urandom_range(0, 7) == 0)
                SLEEP_VOTE = ($urandom_range(0, 2) != 0) ? 4'b1111 : 4'($urandom);
            MBUS_BUSY = ($urandom_range(0, 4) == 0);
            if ($urandom_range(0, 19) == 0) ENABLE = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 29) == 0) begin
                int_dly = $urandom_range(1, 12);
                clr_dly = $urandom_range(1, 12);
                slp_dly = $urandom_range(1, 12);
            end
            if ($urandom_range(0, 599) == 0) begin
                #2 RESET = 1'b1;
                model_reset();
                #1 RESET = 1'b0;
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
